// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the hazard/forwarding scoreboard of the RV32 pipeline.
package hazard_scoreboard_pkg;

    localparam int unsigned CPU_AW      = 5;
    localparam int unsigned FWD_REGFILE = 0;

    localparam int unsigned STAGE_EX  = 0;
    localparam int unsigned STAGE_MEM = 1;
    localparam int unsigned STAGE_WB  = 2;

    typedef struct packed {
        logic              valid;
        logic [CPU_AW-1:0] rd;
        logic              load;
    } entry_t;

endpackage

// File: rtl/hazard_fwd_match.sv
// Youngest-writer priority encoder for one source operand over the matchable stages.
module hazard_fwd_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned AW         = CPU_AW,
    parameter int unsigned TRACK      = 2,
    parameter int unsigned LOAD_READY = STAGE_WB,
    parameter int unsigned FWD_W      = 2
) (
    input  logic [AW-1:0]       src_addr_i,
    input  logic                src_used_i,
    input  logic [TRACK-1:0]    ent_valid_i,
    input  logic [TRACK*AW-1:0] ent_rd_i,
    input  logic [TRACK-1:0]    ent_load_i,
    output logic [FWD_W-1:0]    sel_o,
    output logic                is_load_hit_o
);

    always_comb begin
        sel_o         = FWD_W'(FWD_REGFILE);
        is_load_hit_o = 1'b0;
        if (src_used_i) begin
            // Scan oldest to youngest so the youngest match is the one that sticks.
            for (int j = int'(TRACK) - 1; j >= 0; j--) begin
                if (ent_valid_i[j] && (ent_rd_i[j*AW +: AW] == src_addr_i)) begin
                    sel_o         = FWD_W'(j + 1);
                    is_load_hit_o = ent_load_i[j] && ((j + 1) < int'(LOAD_READY));
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit: tracks in-flight writers, raises load-use stalls,
// registers per-source EX forwarding selects and counts stall cycles.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned AW         = CPU_AW,
    parameter int unsigned DEPTH      = STAGE_WB + 1,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned LOAD_READY = STAGE_WB,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned FWD_W     = $clog2(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     issue_valid_i,
    input  logic [AW-1:0]            issue_rd_i,
    input  logic                     issue_regwr_i,
    input  logic                     issue_load_i,
    input  logic [NUM_SRC*AW-1:0]    src_addr_i,
    input  logic [NUM_SRC-1:0]       src_used_i,
    input  logic                     flush_i,
    output logic                     stall_o,
    output logic [NUM_SRC*FWD_W-1:0] fwd_sel_o,
    output logic [CNT_W-1:0]         stall_cnt_o
);

    // The WB occupant is covered by the register file's write-before-read bypass,
    // so only stages EX..DEPTH-2 need to be held here.
    localparam int unsigned TRACK = DEPTH - 1;

    logic [TRACK-1:0]         valid_q;
    logic [TRACK-1:0]         load_q;
    logic [TRACK*AW-1:0]      rd_q;
    logic [NUM_SRC*FWD_W-1:0] sel_d;
    logic [NUM_SRC*FWD_W-1:0] fwd_sel_q;
    logic [NUM_SRC-1:0]       load_hit;
    logic [CNT_W-1:0]         stall_cnt_q;
    logic                     issue_go;
    logic                     issue_writer;

    for (genvar n = 0; n < int'(NUM_SRC); n++) begin : g_match
        hazard_fwd_match #(
            .AW         (AW),
            .TRACK      (TRACK),
            .LOAD_READY (LOAD_READY),
            .FWD_W      (FWD_W)
        ) u_match (
            .src_addr_i    (src_addr_i[n*AW +: AW]),
            .src_used_i    (src_used_i[n]),
            .ent_valid_i   (valid_q),
            .ent_rd_i      (rd_q),
            .ent_load_i    (load_q),
            .sel_o         (sel_d[n*FWD_W +: FWD_W]),
            .is_load_hit_o (load_hit[n])
        );
    end

    assign stall_o      = issue_valid_i & ~flush_i & (|load_hit);
    assign issue_go     = issue_valid_i & ~stall_o & ~flush_i;
    assign issue_writer = issue_go & issue_regwr_i & (issue_rd_i != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            load_q      <= '0;
            rd_q        <= '0;
            fwd_sel_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q   <= (valid_q << 1) | TRACK'(issue_writer);
            load_q    <= (load_q << 1) | TRACK'(issue_load_i);
            rd_q      <= (rd_q << AW) | (TRACK*AW)'(issue_rd_i);
            fwd_sel_q <= issue_go ? sel_d : '0;
            if (stall_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign fwd_sel_o   = fwd_sel_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised and directed bench for hazard_scoreboard against a history-queue model.
module tb_hazard_scoreboard;

    localparam int DEPTH      = 3;
    localparam int LOAD_READY = 2;

    logic       clk;
    logic       rst;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic       issue_regwr;
    logic       issue_load;
    logic [9:0] src_addr;
    logic [1:0] src_used;
    logic       flush;
    logic       stall;
    logic [3:0] fwd_sel;
    logic [15:0] stall_cnt;
    logic       stall_s;
    logic [3:0] fwd_sel_s;
    logic [1:0] stall_cnt_s;

    hazard_scoreboard u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .issue_regwr_i (issue_regwr),
        .issue_load_i  (issue_load),
        .src_addr_i    (src_addr),
        .src_used_i    (src_used),
        .flush_i       (flush),
        .stall_o       (stall),
        .fwd_sel_o     (fwd_sel),
        .stall_cnt_o   (stall_cnt)
    );

    hazard_scoreboard #(.CNT_W(2)) u_dut_sat (
        .clk_i         (clk),
        .rst_i         (rst),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .issue_regwr_i (issue_regwr),
        .issue_load_i  (issue_load),
        .src_addr_i    (src_addr),
        .src_used_i    (src_used),
        .flush_i       (flush),
        .stall_o       (stall_s),
        .fwd_sel_o     (fwd_sel_s),
        .stall_cnt_o   (stall_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: queue of what entered EX each cycle, newest first.
    typedef struct {
        bit wr;
        int rd;
        bit ld;
    } rec_t;

    rec_t hist[$];
    int   m_fwd[2];
    int   m_cnt;
    int   m_cnt_s;
    int   n_tests;
    int   n_fail;

    function automatic int find_writer(int src);
        for (int j = 0; j < DEPTH - 1 && j < hist.size(); j++) begin
            if (hist[j].wr && hist[j].rd != 0 && hist[j].rd == src) return j;
        end
        return -1;
    endfunction

    function automatic int src_of(int n);
        logic [9:0] s;
        s = src_addr;
        return int'(s[n*5 +: 5]);
    endfunction

    function automatic bit m_stall();
        int j;
        if (!issue_valid || flush) return 1'b0;
        for (int n = 0; n < 2; n++) begin
            if (src_used[n]) begin
                j = find_writer(src_of(n));
                if (j >= 0 && hist[j].ld && (j + 1) < LOAD_READY) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic void model_clock();
        bit   s;
        bit   go;
        int   j;
        rec_t r;
        if (rst) begin
            hist.delete();
            m_fwd[0] = 0;
            m_fwd[1] = 0;
            m_cnt    = 0;
            m_cnt_s  = 0;
            return;
        end
        s  = m_stall();
        go = issue_valid && !s && !flush;
        for (int n = 0; n < 2; n++) begin
            j = (go && src_used[n]) ? find_writer(src_of(n)) : -1;
            m_fwd[n] = (j >= 0) ? j + 1 : 0;
        end
        if (s) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 3) m_cnt_s++;
        end
        r.wr = go && issue_regwr;
        r.rd = int'(issue_rd);
        r.ld = issue_load;
        hist.push_front(r);
        if (hist.size() > DEPTH) void'(hist.pop_back());
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all outputs against the model mid-cycle, then advance one clock.
    task automatic cycle();
        @(negedge clk);
        check("stall", int'(stall), int'(m_stall()));
        check("stall_sat", int'(stall_s), int'(m_stall()));
        check("fwd_sel", int'(fwd_sel), m_fwd[0] + 4 * m_fwd[1]);
        check("stall_cnt", int'(stall_cnt), m_cnt);
        check("stall_cnt_sat", int'(stall_cnt_s), m_cnt_s);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic drive(input bit v, input int rd, input bit wr, input bit ld,
                         input int s0, input int s1, input bit [1:0] used, input bit fl);
        issue_valid = v;
        issue_rd    = 5'(rd);
        issue_regwr = wr;
        issue_load  = ld;
        src_addr    = {5'(s1), 5'(s0)};
        src_used    = used;
        flush       = fl;
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
        repeat (3) cycle();
    endtask

    task automatic rand_inputs();
        drive($urandom_range(3) != 0, $urandom_range(7), $urandom_range(3) != 0,
              $urandom_range(2) == 0, $urandom_range(7), $urandom_range(7),
              2'($urandom_range(3)), $urandom_range(9) == 0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        rand_inputs();
        repeat (2) @(posedge clk);
        #1;
        rand_inputs();
        #1;
        check("rst_stall", int'(stall), 0);
        check("rst_fwd", int'(fwd_sel), 0);
        check("rst_cnt", int'(stall_cnt), 0);
        check("rst_cnt_sat", int'(stall_cnt_s), 0);
        hist.delete();
        m_fwd[0] = 0;
        m_fwd[1] = 0;
        m_cnt    = 0;
        m_cnt_s  = 0;
        rst      = 1'b0;
        drain();

        // Back-to-back producer/consumer forwards from EX latch.
        drive(1, 5, 1, 0, 1, 2, 2'b11, 0); cycle();
        drive(1, 10, 1, 0, 5, 3, 2'b01, 0); cycle();
        check("t2_fwd_ex", int'(fwd_sel[1:0]), 1);
        drain();
        // One independent instruction between: MEM latch.
        drive(1, 5, 1, 0, 1, 2, 2'b11, 0); cycle();
        drive(1, 9, 1, 0, 1, 2, 2'b11, 0); cycle();
        drive(1, 10, 1, 0, 5, 3, 2'b01, 0); cycle();
        check("t2_fwd_mem", int'(fwd_sel[1:0]), 2);
        drain();
        // Two between: producer sits in WB, regfile supplies it.
        drive(1, 5, 1, 0, 1, 2, 2'b11, 0); cycle();
        drive(1, 9, 1, 0, 1, 2, 2'b11, 0); cycle();
        drive(1, 11, 1, 0, 1, 2, 2'b11, 0); cycle();
        drive(1, 10, 1, 0, 5, 3, 2'b01, 0); cycle();
        check("t2_fwd_wb", int'(fwd_sel[1:0]), 0);
        drain();

        // Load-use: one stall, then forward from MEM latch.
        drive(1, 6, 1, 1, 1, 2, 2'b11, 0); cycle();
        drive(1, 12, 1, 0, 1, 6, 2'b11, 0); #1;
        check("t3_stall_on", int'(stall), 1);
        cycle();
        check("t3_cnt", int'(stall_cnt), 1);
        check("t3_bubble", int'(fwd_sel), 0);
        #1;
        check("t3_stall_off", int'(stall), 0);
        cycle();
        check("t3_fwd_src1", int'(fwd_sel[3:2]), 2);
        check("t3_fwd_src0", int'(fwd_sel[1:0]), 0);
        drain();

        // x0 writer never matches; unused source never matches.
        drive(1, 0, 1, 1, 1, 2, 2'b11, 0); cycle();
        drive(1, 12, 1, 0, 0, 0, 2'b11, 0); #1;
        check("t4_x0_stall", int'(stall), 0);
        cycle();
        check("t4_x0_fwd", int'(fwd_sel), 0);
        drain();
        drive(1, 5, 1, 0, 1, 2, 2'b11, 0); cycle();
        drive(1, 12, 1, 0, 5, 5, 2'b00, 0); cycle();
        check("t4_unused_fwd", int'(fwd_sel), 0);
        drain();

        // Two writers of x7: youngest wins on both sources.
        drive(1, 7, 1, 0, 1, 2, 2'b11, 0); cycle();
        drive(1, 7, 1, 0, 7, 2, 2'b11, 0); cycle();
        drive(1, 13, 1, 0, 7, 7, 2'b11, 0); cycle();
        check("t5_youngest", int'(fwd_sel), 5);
        drain();

        // Flush beats load-use.
        drive(1, 6, 1, 1, 1, 2, 2'b11, 0); cycle();
        drive(1, 12, 1, 0, 6, 6, 2'b11, 1); #1;
        check("t6_flush_stall", int'(stall), 0);
        cycle();
        check("t6_flush_fwd", int'(fwd_sel), 0);
        check("t6_flush_cnt", int'(stall_cnt), 1);
        drain();

        // Four more load-use stalls: 5 total, narrow counter pinned at 3.
        repeat (4) begin
            drive(1, 6, 1, 1, 1, 2, 2'b11, 0); cycle();
            drive(1, 12, 1, 0, 6, 1, 2'b01, 0); cycle(); cycle();
            drain();
        end
        check("t6_cnt5", int'(stall_cnt), 5);
        check("t6_sat", int'(stall_cnt_s), 3);

        // Reset mid-stream drops the pending load.
        drive(1, 6, 1, 1, 1, 2, 2'b11, 0); cycle();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0); cycle();
        rst = 1'b0;
        drive(1, 12, 1, 0, 6, 6, 2'b11, 0); #1;
        check("t1_midrst_stall", int'(stall), 0);
        check("t1_midrst_cnt", int'(stall_cnt), 0);
        cycle();
        check("t1_midrst_fwd", int'(fwd_sel), 0);
        drain();

        repeat (3000) begin
            rst = ($urandom_range(299) == 0);
            rand_inputs();
            cycle();
        end
        rst = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
